// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift, rotate, arithmetic shift and clear,
// with a serial-out tap, a cycle enable and a burst engine that performs N shifts
// autonomously and reports completion with a busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [2:0]       mode_i,
  input  logic             D,
  input  logic [WIDTH-1:0] par_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] P,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    ModeHold  = 3'b000,
    ModeLoad  = 3'b001,
    ModeShl   = 3'b010,
    ModeShr   = 3'b011,
    ModeRol   = 3'b100,
    ModeRor   = 3'b101,
    ModeAsr   = 3'b110,
    ModeClear = 3'b111
  } mode_e;

  typedef enum logic {
    StIdle,
    StBurst
  } state_e;

  state_e           state_q;
  mode_e            burst_mode_q;
  logic [CNT_W-1:0] remaining_q;
  logic [WIDTH-1:0] p_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;

  // Operation selected for this cycle and its combinational result.
  mode_e            op_mode;
  logic [WIDTH-1:0] op_p;
  logic             op_sout;
  logic             mode_is_shift;
  logic             last_shift;

  // Only shift-class modes (SHL..ASR) may launch a burst.
  assign mode_is_shift = (mode_i >= ModeShl) && (mode_i <= ModeAsr);

  // The final burst shift is the one taken while a single shift remains.
  assign last_shift = (remaining_q == CNT_W'(1));

  // Next register value and serial-out for the active mode; during a burst the latched
  // mode is used so mode_i changes cannot disturb it.
  always_comb begin
    op_mode = (state_q == StBurst) ? burst_mode_q : mode_e'(mode_i);
    op_p    = p_q;
    op_sout = sout_q;
    unique case (op_mode)
      ModeHold: begin
        op_p = p_q;
      end
      ModeLoad: begin
        op_p = par_i;
      end
      ModeShl: begin
        op_p    = {p_q[WIDTH-2:0], D};
        op_sout = p_q[WIDTH-1];
      end
      ModeShr: begin
        op_p    = {D, p_q[WIDTH-1:1]};
        op_sout = p_q[0];
      end
      ModeRol: begin
        op_p    = {p_q[WIDTH-2:0], p_q[WIDTH-1]};
        op_sout = p_q[WIDTH-1];
      end
      ModeRor: begin
        op_p    = {p_q[0], p_q[WIDTH-1:1]};
        op_sout = p_q[0];
      end
      ModeAsr: begin
        op_p    = {p_q[WIDTH-1], p_q[WIDTH-1:1]};
        op_sout = p_q[0];
      end
      ModeClear: begin
        op_p = '0;
      end
      default: begin
        op_p = p_q;
      end
    endcase
  end

  // Control FSM and datapath registers; all outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= StIdle;
      burst_mode_q <= ModeHold;
      remaining_q  <= '0;
      p_q          <= '0;
      sout_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // done is a single-cycle pulse and drops even while en is low.
      done_q <= 1'b0;
      if (en) begin
        unique case (state_q)
          StIdle: begin
            if (start_i && mode_is_shift) begin
              if (cnt_i == '0) begin
                // Empty burst: nothing to shift, just acknowledge.
                done_q <= 1'b1;
              end else begin
                // Launch edge only captures the command; shifting starts next edge.
                burst_mode_q <= mode_e'(mode_i);
                remaining_q  <= cnt_i;
                state_q      <= StBurst;
                busy_q       <= 1'b1;
              end
            end else begin
              p_q    <= op_p;
              sout_q <= op_sout;
            end
          end
          StBurst: begin
            p_q         <= op_p;
            sout_q      <= op_sout;
            remaining_q <= remaining_q - CNT_W'(1);
            if (last_shift) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign P      = p_q;
  assign sout_o = sout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus a randomized
// run against an arithmetic reference model of the register.
module tb_univ_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W) + 1;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic          clk;
  logic          nrst;
  logic          en;
  logic [2:0]    mode_i;
  logic          D;
  logic [W-1:0]  par_i;
  logic          start_i;
  logic [CW-1:0] cnt_i;
  logic [W-1:0]  P;
  logic          sout_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  // Reference model state for the randomized run.
  logic [7:0] exp_p;
  logic       exp_s;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .en     (en),
    .mode_i (mode_i),
    .D      (D),
    .par_i  (par_i),
    .start_i(start_i),
    .cnt_i  (cnt_i),
    .P      (P),
    .sout_o (sout_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic model of one register operation, returns {sout, P}.
  function automatic logic [8:0] ref_op(input int m, input int p, input int d, input int par,
                                        input int s);
    int np;
    int ns;
    np = p;
    ns = s;
    case (m)
      1: np = par;
      2: begin np = (p * 2 + d) % 256; ns = p / 128; end
      3: begin np = p / 2 + d * 128;   ns = p % 2;   end
      4: begin np = (p * 2) % 256 + p / 128; ns = p / 128; end
      5: begin np = p / 2 + (p % 2) * 128;   ns = p % 2;   end
      6: begin np = p / 2 + ((p >= 128) ? 128 : 0); ns = p % 2; end
      7: np = 0;
      default: np = p;
    endcase
    return {ns[0], np[7:0]};
  endfunction

  task automatic set_idle_inputs();
    en = 1'b1; mode_i = HOLD; start_i = 1'b0; cnt_i = '0; D = 1'b0; par_i = '0;
  endtask

  task automatic do_load(input logic [7:0] v);
    en = 1'b1; start_i = 1'b0; mode_i = LOAD; par_i = v;
    tick();
    mode_i = HOLD;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); mode_i = 3'($urandom); D = 1'($urandom);
      par_i = 8'($urandom); start_i = 1'($urandom); cnt_i = CW'($urandom);
      tick();
    end
    checks++; if (P !== 8'h00) begin errors++; $display("FAIL reset_p got=%h exp=00", P); end
    checks++; if (sout_o !== 1'b0) begin errors++; $display("FAIL reset_sout got=%b exp=0", sout_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    set_idle_inputs();
    nrst = 1'b1;
    do_load(8'hA5);
    checks++; if (P !== 8'hA5) begin errors++; $display("FAIL reset_load got=%h exp=a5", P); end
  endtask

  task automatic test_single_ops();
    mode_i = SHL; D = 1'b1; tick();
    checks++; if (P !== 8'h4B) begin errors++; $display("FAIL shl_p got=%h exp=4b", P); end
    checks++; if (sout_o !== 1'b1) begin errors++; $display("FAIL shl_sout got=%b exp=1", sout_o); end
    mode_i = SHR; D = 1'b0; tick();
    checks++; if (P !== 8'h25) begin errors++; $display("FAIL shr_p got=%h exp=25", P); end
    checks++; if (sout_o !== 1'b1) begin errors++; $display("FAIL shr_sout got=%b exp=1", sout_o); end
    do_load(8'h80);
    mode_i = ASR; D = 1'b1; tick();
    checks++; if (P !== 8'hC0) begin errors++; $display("FAIL asr_p got=%h exp=c0", P); end
    checks++; if (sout_o !== 1'b0) begin errors++; $display("FAIL asr_sout got=%b exp=0", sout_o); end
    do_load(8'h01);
    mode_i = ROR; tick();
    checks++; if (P !== 8'h80) begin errors++; $display("FAIL ror_p got=%h exp=80", P); end
    checks++; if (sout_o !== 1'b1) begin errors++; $display("FAIL ror_sout got=%b exp=1", sout_o); end
    mode_i = CLR; tick();
    checks++; if (P !== 8'h00) begin errors++; $display("FAIL clear_p got=%h exp=00", P); end
    do_load(8'h3C);
    en = 1'b0; mode_i = SHL; D = 1'b1; tick();
    checks++; if (P !== 8'h3C) begin errors++; $display("FAIL en_low_p got=%h exp=3c", P); end
    set_idle_inputs();
  endtask

  task automatic test_burst_rol();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h03; exp_seq[1] = 8'h06; exp_seq[2] = 8'h0C;
    do_load(8'h81);
    start_i = 1'b1; mode_i = ROL; cnt_i = CW'(3); tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rol_busy0 got=%b exp=1", busy_o); end
    checks++; if (P !== 8'h81) begin errors++; $display("FAIL rol_launch_p got=%h exp=81", P); end
    start_i = 1'b0; mode_i = CLR; par_i = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (P !== exp_seq[k]) begin errors++; $display("FAIL rol_step%0d got=%h exp=%h", k, P, exp_seq[k]); end
      checks++;
      if (busy_o !== (k < 2)) begin errors++; $display("FAIL rol_busy%0d got=%b exp=%b", k + 1, busy_o, k < 2); end
      checks++;
      if (done_o !== (k == 2)) begin errors++; $display("FAIL rol_done%0d got=%b exp=%b", k + 1, done_o, k == 2); end
    end
    checks++; if (sout_o !== 1'b0) begin errors++; $display("FAIL rol_sout got=%b exp=0", sout_o); end
    mode_i = HOLD; tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rol_done_drop got=%b exp=0", done_o); end
    set_idle_inputs();
  endtask

  task automatic test_burst_stall();
    logic [7:0] prev;
    logic [7:0] model;
    do_load(8'h80);
    model = 8'h80;
    start_i = 1'b1; mode_i = ASR; cnt_i = CW'(8); tick();
    start_i = 1'b0; mode_i = LOAD; par_i = 8'h11;
    for (int k = 1; k <= 10; k++) begin
      prev = P;
      en = !(k == 3 || k == 4);
      tick();
      if (en) model = {model[7], model[7:1]};
      else begin
        checks++;
        if (P !== prev) begin errors++; $display("FAIL stall_frozen%0d got=%h exp=%h", k, P, prev); end
      end
      checks++;
      if (done_o !== (k == 10)) begin errors++; $display("FAIL stall_done%0d got=%b exp=%b", k, done_o, k == 10); end
    end
    checks++; if (P !== 8'hFF) begin errors++; $display("FAIL stall_final got=%h exp=ff", P); end
    checks++; if (P !== model) begin errors++; $display("FAIL stall_model got=%h exp=%h", P, model); end
    set_idle_inputs();
    tick();
  endtask

  task automatic test_burst_abort();
    do_load(8'hF0);
    start_i = 1'b1; mode_i = SHR; cnt_i = CW'(5); D = 1'b1; tick();
    start_i = 1'b0;
    tick(); tick();
    checks++; if (P !== 8'hFC) begin errors++; $display("FAIL abort_pre got=%h exp=fc", P); end
    nrst = 1'b0; tick();
    checks++; if (P !== 8'h00) begin errors++; $display("FAIL abort_p got=%h exp=00", P); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    nrst = 1'b1; mode_i = HOLD;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL abort_no_done%0d got=%b%b exp=00", k, done_o, busy_o);
      end
    end
    set_idle_inputs();
  endtask

  task automatic test_boundaries();
    int cyc;
    do_load(8'h5A);
    start_i = 1'b1; mode_i = SHL; cnt_i = '0; D = 1'b1; tick();
    checks++; if (P !== 8'h5A) begin errors++; $display("FAIL cnt0_p got=%h exp=5a", P); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL cnt0_done got=%b exp=1", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cnt0_busy got=%b exp=0", busy_o); end
    start_i = 1'b0; mode_i = HOLD; tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL cnt0_drop got=%b exp=0", done_o); end
    do_load(8'h01);
    start_i = 1'b1; mode_i = ROR; cnt_i = CW'(9); tick();
    start_i = 1'b0; mode_i = HOLD;
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL ror9_cycles got=%0d exp=9", cyc); end
    checks++; if (P !== 8'h80) begin errors++; $display("FAIL ror9_p got=%h exp=80", P); end
    start_i = 1'b1; mode_i = LOAD; par_i = 8'h3C; cnt_i = CW'(4); tick();
    checks++; if (P !== 8'h3C) begin errors++; $display("FAIL start_load_p got=%h exp=3c", P); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_load_busy got=%b exp=0", busy_o); end
    set_idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int m;
    int n;
    int left;
    int cyc;
    exp_p = 8'($urandom);
    do_load(exp_p);
    exp_s = sout_o === 1'b1;
    // sout value before the random run is whatever prior ops left; take one known shift.
    mode_i = SHL; D = 1'b0; tick();
    {exp_s, exp_p} = ref_op(2, int'(exp_p), 0, 0, 0);
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        m = $urandom_range(0, 7);
        en = ($urandom_range(0, 3) != 0); mode_i = 3'(m); start_i = 1'b0;
        D = 1'($urandom); par_i = 8'($urandom); cnt_i = CW'($urandom);
        tick();
        if (en) {exp_s, exp_p} = ref_op(m, int'(exp_p), int'(D), int'(par_i), int'(exp_s));
        checks++;
        if (P !== exp_p || sout_o !== exp_s || busy_o !== 1'b0 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_op%0d got=%h/%b/%b%b exp=%h/%b/00", it, P, sout_o, busy_o, done_o,
                   exp_p, exp_s);
        end
      end else begin
        m = $urandom_range(2, 6);
        n = $urandom_range(0, 15);
        en = 1'b1; start_i = 1'b1; mode_i = 3'(m); cnt_i = CW'(n); D = 1'($urandom);
        tick();
        start_i = 1'($urandom); mode_i = 3'($urandom); cnt_i = CW'($urandom);
        checks++;
        if (P !== exp_p || busy_o !== (n != 0) || done_o !== (n == 0)) begin
          errors++;
          $display("FAIL rand_launch%0d got=%h/%b%b exp=%h/%b%b", it, P, busy_o, done_o, exp_p,
                   n != 0, n == 0);
        end
        left = n;
        cyc = 0;
        while (left > 0 && cyc < 64) begin
          en = ($urandom_range(0, 3) != 0); D = 1'($urandom); par_i = 8'($urandom);
          tick();
          cyc++;
          if (en) begin
            {exp_s, exp_p} = ref_op(m, int'(exp_p), int'(D), 0, int'(exp_s));
            left--;
          end
          checks++;
          if (P !== exp_p || sout_o !== exp_s || busy_o !== (left != 0) ||
              done_o !== (en && left == 0)) begin
            errors++;
            $display("FAIL rand_burst%0d got=%h/%b/%b%b exp=%h/%b/%b%b", it, P, sout_o, busy_o,
                     done_o, exp_p, exp_s, left != 0, en && left == 0);
          end
        end
        if (left != 0) begin
          checks++; errors++;
          $display("FAIL rand_timeout%0d got=%0d exp=0 shifts left", it, left);
        end
        start_i = 1'b0;
      end
    end
    set_idle_inputs();
    tick();
  endtask

  initial begin
    set_idle_inputs();
    nrst = 1'b0;
    test_reset();
    test_single_ops();
    test_burst_rol();
    test_burst_stall();
    test_burst_abort();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the next-generation replacement for the fixed 8-bit shift register in the RTL library. It adds configurable width, rotate, arithmetic-shift and clear modes, a serial-out tap, a clock enable, and a multi-cycle burst engine. The burst engine performs N shifts autonomously and signals completion with a busy/done handshake. It sits between control FSMs and serial/parallel datapaths.

## Interface

- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH)+1, width of burst count input

Ports:

- clk  in  1  system clock; all state updates on posedge
- nrst  in  1  reset, synchronous, active-low
- en  in  1  cycle enable; low = no state change (burst paused)
- mode_i  in  3  000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR
- D  in  1  serial input: enters LSB on SHL, MSB on SHR
- par_i  in  WIDTH  parallel load data
- start_i  in  1  request burst of cnt_i shifts using mode_i
- cnt_i  in  CNT_W  burst shift count
- P  out  WIDTH  parallel register contents
- sout_o  out  1  bit most recently shifted/rotated out
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse, burst complete

## Operation

- Reset (nrst low at posedge):
  - P=0, sout_o=0, busy_o=0, done_o=0, state=IDLE.
  - Reset mid-burst aborts the burst with no done_o pulse.
- Per-mode next value of P:
  - HOLD: P.
  - LOAD: par_i.
  - SHL: {P[W-2:0],D}.
  - SHR: {D,P[W-1:1]}.
  - ROL: {P[W-2:0],P[W-1]}.
  - ROR: {P[0],P[W-1:1]}.
  - ASR: {P[W-1],P[W-1:1]}.
  - CLEAR: 0.
- sout_o:
  - SHL/ROL: loads the old P[W-1].
  - SHR/ROR/ASR: loads the old P[0].
  - All other modes: holds.
- FSM IDLE:
  - en high, start_i low: execute mode_i once per cycle.
  - en high, start_i high, mode_i in a shift class (010–110):
    - cnt_i=0: no shift, P unchanged; done_o=1 next cycle; stay IDLE.
    - cnt_i≥1: latch mode_i into burst_mode and cnt_i into remaining. P is not changed this edge. Go to BURST, busy_o=1.
  - start_i with HOLD/LOAD/CLEAR: start_i ignored; mode executes normally.
- FSM BURST:
  - Each enabled cycle performs one burst_mode shift and decrements remaining.
  - On the edge performing the final shift (remaining==1): go to IDLE, busy_o=0, done_o=1.
  - mode_i, par_i, start_i and cnt_i are ignored throughout BURST.
  - en low freezes P, remaining and sout_o.
- Counts above WIDTH are legal and are not clamped:
  - Shifts fill entirely with D, or with the sign bit for ASR.
  - Rotates wrap modulo WIDTH in effect.
- done_o is high for exactly one cycle, cleared on the next edge regardless of en.

## Timing

- Single-op latency: P updates at the posedge sampling en=1 with mode_i.
- Burst sampled at edge 0 with cnt_i=N:
  - busy_o=1 after edge 0.
  - Shifts occur at edges 1..N when en=1; each en=0 cycle adds one cycle.
  - busy_o=0 and done_o=1 after edge N; done_o=0 after edge N+1.
- New start_i is accepted in the same cycle done_o is high (state is IDLE).
- All outputs are registered; no combinational input-to-output paths.

## Test plan

All scenarios use WIDTH=8.

1. Reset: hold nrst=0 two cycles with random inputs -> P=0x00, sout_o=0, busy_o=0, done_o=0. Release, then LOAD par_i=0xA5 -> P=0xA5 next edge.
2. Single ops from P=0xA5:
   - SHL D=1 -> 0x4B, sout_o=1.
   - Then SHR D=0 -> 0x25, sout_o=1.
   - LOAD 0x80, ASR -> 0xC0, sout_o=0.
   - LOAD 0x01, ROR -> 0x80, sout_o=1.
   - CLEAR -> 0x00.
   - en=0 with SHL -> P unchanged.
3. Burst ROL:
   - Setup: P=0x81, start_i=1, mode_i=ROL, cnt_i=3.
   - Response: busy_o high 3 cycles; P=0x03, 0x06, 0x0C; then done_o=1 for one cycle; sout_o=0.
   - mode_i=CLEAR applied mid-burst must have no effect.
4. Burst stall:
   - Setup: ASR burst on 0x80, cnt_i=8, en=0 for 2 cycles mid-burst.
   - Response: P ends 0xFF; done_o appears 10 edges after start; P frozen during stall.
5. Burst reset abort: start SHR cnt_i=5, assert nrst=0 after 2 shifts -> P=0, busy_o=0, no done_o pulse.
6. Burst boundaries:
   - start_i with cnt_i=0 -> P unchanged, done_o pulse next cycle, busy_o never high.
   - ROR burst cnt_i=9 on 0x01 -> P=0x80.
   - start_i with mode LOAD -> plain load, no busy_o.
